// File: rtl/io_terminal_pkg.sv
// Shared types and sizing helpers for the io_terminal serial I/O responder.
package io_terminal_pkg;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop,
        RxWaitHigh
    } rx_state_t;

    typedef enum logic [1:0] {
        TxIdle,
        TxStart,
        TxData,
        TxStop
    } tx_state_t;

    localparam int unsigned DEF_CLKS_PER_BIT = 16;
    localparam int unsigned DEF_DATA_W       = 8;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int unsigned width_for(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_terminal_sync2.sv
// Two-flop synchroniser for an idle-high asynchronous input; resets to 1.
module io_terminal_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/io_terminal.sv
// Peripheral side of the INP/OUT instructions: serial receiver into INPR with FGI,
// serial transmitter from OUTR with FGO, and the registered interrupt request.
module io_terminal
    import io_terminal_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned DATA_W       = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rxd,
    output logic              txd,
    output logic [DATA_W-1:0] inpr,
    output logic              fgi,
    input  logic              inp_ack,
    input  logic [DATA_W-1:0] outr_in,
    input  logic              out_ld,
    output logic              fgo,
    input  logic              ien,
    output logic              irq,
    output logic              rx_overrun,
    output logic              rx_frame_err
);

    localparam int unsigned CNT_W = width_for(CLKS_PER_BIT);
    localparam int unsigned IDX_W = width_for(DATA_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    logic              rx_s, rx_prev_q;
    rx_state_t         rx_state_q, rx_state_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [IDX_W-1:0]  rx_idx_q, rx_idx_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] inpr_q, inpr_d;
    logic              fgi_q, fgi_d, ovr_q, ovr_d, ferr_q, ferr_d;

    tx_state_t         tx_state_q, tx_state_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [IDX_W-1:0]  tx_idx_q, tx_idx_d;
    logic [DATA_W-1:0] outr_q, outr_d;
    logic              txd_q, txd_d, fgo_q, fgo_d, irq_q;

    io_terminal_sync2 u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rxd),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_prev_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            inpr_q     <= '0;
            fgi_q      <= 1'b0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_prev_q  <= rx_s;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            inpr_q     <= inpr_d;
            fgi_q      <= fgi_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        inpr_d     = inpr_q;
        fgi_d      = fgi_q;
        ovr_d      = ovr_q;
        ferr_d     = ferr_q;
        // The CPU acknowledge is applied before any stop-bit decision below.
        if (inp_ack) begin
            fgi_d  = 1'b0;
            ovr_d  = 1'b0;
            ferr_d = 1'b0;
        end
        unique case (rx_state_q)
            RxIdle: begin
                if (rx_prev_q && !rx_s) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = '0;
                end
            end
            RxStart: begin
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = '0;
                    rx_state_d = rx_s ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RxData: begin
                if (rx_cnt_q == CNT_FULL) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift_q[DATA_W-1:1]};
                    if (rx_idx_q == IDX_LAST) begin
                        rx_state_d = RxStop;
                    end else begin
                        rx_idx_d = rx_idx_q + IDX_W'(1);
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RxStop: begin
                if (rx_cnt_q == CNT_FULL) begin
                    rx_cnt_d = '0;
                    if (rx_s) begin
                        if (!fgi_d) begin
                            inpr_d = rx_shift_q;
                            fgi_d  = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                        rx_state_d = RxIdle;
                    end else begin
                        ferr_d     = 1'b1;
                        rx_state_d = RxWaitHigh;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RxWaitHigh: begin
                if (rx_s) rx_state_d = RxIdle;
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            outr_q     <= '0;
            txd_q      <= 1'b1;
            fgo_q      <= 1'b1;
            irq_q      <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            outr_q     <= outr_d;
            txd_q      <= txd_d;
            fgo_q      <= fgo_d;
            irq_q      <= ien & (fgi_q | fgo_q);
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        outr_d     = outr_q;
        txd_d      = txd_q;
        fgo_d      = fgo_q;
        unique case (tx_state_q)
            TxIdle: begin
                txd_d = 1'b1;
                if (out_ld && fgo_q) begin
                    outr_d     = outr_in;
                    fgo_d      = 1'b0;
                    tx_cnt_d   = '0;
                    txd_d      = 1'b0;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (tx_cnt_q == CNT_FULL) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    txd_d      = outr_q[0];
                    tx_state_d = TxData;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            TxData: begin
                if (tx_cnt_q == CNT_FULL) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == IDX_LAST) begin
                        txd_d      = 1'b1;
                        tx_state_d = TxStop;
                    end else begin
                        tx_idx_d = tx_idx_q + IDX_W'(1);
                        txd_d    = outr_q[tx_idx_q + IDX_W'(1)];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            TxStop: begin
                if (tx_cnt_q == CNT_FULL) begin
                    tx_cnt_d   = '0;
                    fgo_d      = 1'b1;
                    tx_state_d = TxIdle;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    assign txd          = txd_q;
    assign inpr         = inpr_q;
    assign fgi          = fgi_q;
    assign fgo          = fgo_q;
    assign irq          = irq_q;
    assign rx_overrun   = ovr_q;
    assign rx_frame_err = ferr_q;

endmodule

// File: tb/tb_io_terminal.sv
// Self-checking bench for io_terminal: frame-level reference model plus directed literal checks.
module tb_io_terminal;

    localparam int C = 16;
    localparam int D = 8;

    logic       clk;
    logic       reset, rxd, inp_ack, out_ld, ien;
    logic [7:0] outr_in;
    logic       txd, fgi, fgo, irq, rx_overrun, rx_frame_err;
    logic [7:0] inpr;

    io_terminal #(
        .CLKS_PER_BIT (C),
        .DATA_W       (D)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rxd          (rxd),
        .txd          (txd),
        .inpr         (inpr),
        .fgi          (fgi),
        .inp_ack      (inp_ack),
        .outr_in      (outr_in),
        .out_ld       (out_ld),
        .fgo          (fgo),
        .ien          (ien),
        .irq          (irq),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state.
    int         cyc, m_tx_t0;
    logic [7:0] m_tx_byte, m_inpr, rx_pend_byte;
    bit         m_fgo, m_fgi, m_ovr, m_ferr, m_irq, m_txd;
    int         rx_pend;
    bit         rx_busy, chk_en;

    task automatic m_reset();
        m_fgo = 1; m_fgi = 0; m_ovr = 0; m_ferr = 0; m_irq = 0; m_txd = 1;
        m_inpr = 8'h00; m_tx_byte = 8'h00; m_tx_t0 = 0; rx_pend = 0;
    endtask

    // Line level t cycles after the edge that accepted the byte.
    function automatic bit tx_bit(input int t, input logic [7:0] b);
        if (t < C) return 1'b0;
        else if (t < (D + 1) * C) return b[t / C - 1];
        else return 1'b1;
    endfunction

    initial begin : model
        bit fgo_pre, irq_n;
        cyc = 0;
        m_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_reset();
            end else begin
                cyc++;
                irq_n   = ien && (m_fgi || m_fgo);
                fgo_pre = m_fgo;
                if (!m_fgo && (cyc - m_tx_t0 == (D + 2) * C)) m_fgo = 1'b1;
                if (out_ld && fgo_pre) begin
                    m_fgo = 1'b0; m_tx_t0 = cyc; m_tx_byte = outr_in;
                end
                if (inp_ack) begin
                    m_fgi = 0; m_ovr = 0; m_ferr = 0;
                end
                if (rx_pend == 1) begin
                    if (!m_fgi) begin
                        m_inpr = rx_pend_byte; m_fgi = 1'b1;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end else if (rx_pend == 2) begin
                    m_ferr = 1'b1;
                end
                rx_pend = 0;
                m_irq   = irq_n;
                m_txd   = m_fgo ? 1'b1 : tx_bit(cyc - m_tx_t0, m_tx_byte);
            end
        end
    end

    // RX outputs are left unchecked only while a frame is on the line.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("txd", txd, m_txd);
                chk("fgo", fgo, m_fgo);
                if (!rx_busy) begin
                    chk("inpr", inpr, m_inpr);
                    chk("fgi", fgi, m_fgi);
                    chk("rx_overrun", rx_overrun, m_ovr);
                    chk("rx_frame_err", rx_frame_err, m_ferr);
                    chk("irq", irq, m_irq);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ack_pulse();
        inp_ack = 1'b1;
        tick(1);
        inp_ack = 1'b0;
    endtask

    // ack_off: cycle offset (from start-bit launch) at which inp_ack is raised, -1 for none.
    task automatic send_frame(input logic [7:0] b, input bit stop, input int ack_off,
                              input int extra);
        logic [9:0] fr;
        fr      = {stop, b, 1'b0};
        rx_busy = 1'b1;
        for (int o = 0; o < 10 * C; o++) begin
            rxd     = fr[o / C];
            inp_ack = (o == ack_off);
            tick(1);
        end
        inp_ack = 1'b0;
        if (extra > 0) tick(extra);
        rxd          = 1'b1;
        rx_pend_byte = b;
        rx_pend      = stop ? 1 : 2;
        tick(4);
        rx_busy = 1'b0;
    endtask

    initial begin : main
        logic [9:0] seen;
        logic [9:0] want;
        int         fgo_low;
        int         sel;
        want    = 10'b11_1010_0101 << 1;
        reset   = 1'b0; rxd = 1'b1; inp_ack = 1'b0; out_ld = 1'b0; ien = 1'b0;
        outr_in = 8'h00; rx_busy = 1'b0; chk_en = 1'b0;
        tick(3);
        reset = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_fgo", fgo, 1'b1);
        chk("rst_fgi", fgi, 1'b0);
        chk("rst_txd", txd, 1'b1);
        chk("rst_irq", irq, 1'b0);
        @(posedge clk); #1;
        ien = 1'b1;
        @(negedge clk);
        chk("irq_same_cycle", irq, 1'b0);
        @(negedge clk);
        chk("irq_next_cycle", irq, 1'b1);
        @(posedge clk); #1;

        // 0xA5 frame, with an ignored load of 0x0F half way through.
        outr_in = 8'hA5; out_ld = 1'b1;
        tick(1);
        out_ld  = 1'b0;
        fgo_low = 0;
        seen    = '0;
        for (int o = 0; o <= 10 * C; o++) begin
            @(negedge clk);
            if (o < 10 * C && fgo == 1'b0) fgo_low++;
            if (o % C == C / 2 && o < 10 * C) seen[o / C] = txd;
            if (o == 10 * C) chk("a5_fgo_end", fgo, 1'b1);
            if (o == 80) begin
                outr_in = 8'h0F; out_ld = 1'b1;
            end else if (o == 81) begin
                out_ld = 1'b0;
            end
        end
        for (int k = 0; k < 10; k++) chk($sformatf("a5_bit%0d", k), seen[k], want[k]);
        chk("a5_fgo_low_cycles", fgo_low, 160);
        tick(2);

        send_frame(8'h3C, 1'b1, -1, 0);
        @(negedge clk);
        chk("rx3c_inpr", inpr, 8'h3C);
        chk("rx3c_fgi", fgi, 1'b1);
        @(posedge clk); #1;
        ack_pulse();
        @(negedge clk);
        chk("ack_fgi", fgi, 1'b0);
        chk("ack_inpr", inpr, 8'h3C);
        @(posedge clk); #1;

        send_frame(8'h11, 1'b1, -1, 0);
        send_frame(8'h22, 1'b1, -1, 0);
        @(negedge clk);
        chk("ovr_inpr", inpr, 8'h11);
        chk("ovr_flag", rx_overrun, 1'b1);
        @(posedge clk); #1;
        ack_pulse();
        send_frame(8'h11, 1'b1, -1, 0);
        send_frame(8'h22, 1'b1, 154, 0);
        @(negedge clk);
        chk("coinc_inpr", inpr, 8'h22);
        chk("coinc_fgi", fgi, 1'b1);
        chk("coinc_ovr", rx_overrun, 1'b0);
        @(posedge clk); #1;
        ack_pulse();

        send_frame(8'h55, 1'b0, -1, 40);
        @(negedge clk);
        chk("ferr_fgi", fgi, 1'b0);
        chk("ferr_flag", rx_frame_err, 1'b1);
        chk("ferr_inpr", inpr, 8'h22);
        @(posedge clk); #1;
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(30);
        @(negedge clk);
        chk("glitch_fgi", fgi, 1'b0);
        chk("glitch_inpr", inpr, 8'h22);
        @(posedge clk); #1;
        ack_pulse();

        // Full-duplex random traffic.
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    tick($urandom_range(1, 220));
                    outr_in = 8'($urandom);
                    out_ld  = 1'b1;
                    tick(1);
                    out_ld  = 1'b0;
                end
            end
            begin
                for (int j = 0; j < 12; j++) begin
                    sel = $urandom_range(0, 9);
                    if (sel < 3) ack_pulse();
                    send_frame(8'($urandom), sel != 9, (sel == 3) ? 154 : -1,
                               (sel == 9) ? $urandom_range(0, 20) : 0);
                    tick($urandom_range(0, 30));
                end
            end
        join
        tick(200);

        // Reset in the middle of a transmit frame.
        outr_in = 8'hC3; out_ld = 1'b1;
        tick(1);
        out_ld = 1'b0;
        tick(50);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_txd", txd, 1'b1);
        chk("midrst_fgo", fgo, 1'b1);
        chk("midrst_inpr", inpr, 8'h00);
        @(posedge clk); #1;
        tick(2);
        reset = 1'b1;
        tick(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
